// File: rtl/jtag_mem_arbiter_if.sv
// One master's request/response channel toward the boot-RAM arbiter.
// The master drives the request and its qualifiers; the arbiter returns the grant and read data.
interface jtag_mem_arbiter_if;
    logic        req;
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [63:0] rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/jtag_mem_arbiter.sv
// Shares one 64-bit single-port boot RAM between the JTAG loader (M0) and the system master (M1).
// Round-robin with bounded bus lock; read data is steered back by a tag pipe.
module jtag_mem_arbiter #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned MAX_LOCK    = 16
) (
    input  logic                     tck_i,
    input  logic                     reset_i,
    jtag_mem_arbiter_if.slave        m0_if,
    jtag_mem_arbiter_if.slave        m1_if,
    output logic                     mem_en_o,
    output logic                     wren_o,
    output logic [31:0]              addr_o,
    output logic [63:0]              to_mem_o,
    input  logic [63:0]              from_mem_i
);

    localparam int unsigned DEPTH      = MEM_LATENCY + 1;
    localparam logic [7:0]  MAX_LOCK_C = 8'(MAX_LOCK);

    logic             last_q, last_d;
    logic             lock_v_q, lock_v_d;
    logic             lock_owner_q, lock_owner_d;
    logic [7:0]       lock_cnt_q, lock_cnt_d;
    logic             mem_en_q, mem_en_d;
    logic             wren_q, wren_d;
    logic [31:0]      addr_q, addr_d;
    logic [63:0]      to_mem_q, to_mem_d;
    logic [DEPTH-1:0] tag_v_q, tag_v_d;
    logic [DEPTH-1:0] tag_id_q, tag_id_d;
    logic             rvalid0_q, rvalid0_d;
    logic             rvalid1_q, rvalid1_d;
    logic [63:0]      rdata0_q, rdata0_d;
    logic [63:0]      rdata1_q, rdata1_d;

    logic [1:0]       req_s;
    logic             grant_s;
    logic             gnt_id_s;
    logic             other_req_s;
    logic             sel_we_s;
    logic             sel_lock_s;
    logic [31:0]      sel_addr_s;
    logic [63:0]      sel_wdata_s;
    logic             lock_same_s;

    assign req_s = {m1_if.req, m0_if.req};

    // Arbitration: a live lock below its starvation limit wins a tie, else the non-last master.
    always_comb begin
        grant_s  = 1'b0;
        gnt_id_s = 1'b0;
        case (req_s)
            2'b01: begin
                grant_s  = 1'b1;
                gnt_id_s = 1'b0;
            end
            2'b10: begin
                grant_s  = 1'b1;
                gnt_id_s = 1'b1;
            end
            2'b11: begin
                grant_s = 1'b1;
                if (lock_v_q && (lock_cnt_q < MAX_LOCK_C)) begin
                    gnt_id_s = lock_owner_q;
                end else begin
                    gnt_id_s = ~last_q;
                end
            end
            default: begin
                grant_s  = 1'b0;
                gnt_id_s = 1'b0;
            end
        endcase
    end

    assign m0_if.gnt = grant_s & ~gnt_id_s;
    assign m1_if.gnt = grant_s &  gnt_id_s;

    // Qualifier mux for the granted master.
    always_comb begin
        if (gnt_id_s) begin
            sel_we_s    = m1_if.we;
            sel_lock_s  = m1_if.lock;
            sel_addr_s  = m1_if.addr;
            sel_wdata_s = m1_if.wdata;
            other_req_s = m0_if.req;
        end else begin
            sel_we_s    = m0_if.we;
            sel_lock_s  = m0_if.lock;
            sel_addr_s  = m0_if.addr;
            sel_wdata_s = m0_if.wdata;
            other_req_s = m1_if.req;
        end
    end

    assign lock_same_s = lock_v_q && (lock_owner_q == gnt_id_s);

    // Next state for arbitration history, lock tracking and the memory port registers.
    always_comb begin
        last_d       = last_q;
        lock_v_d     = lock_v_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        mem_en_d     = 1'b0;
        wren_d       = 1'b0;
        addr_d       = addr_q;
        to_mem_d     = to_mem_q;
        if (grant_s) begin
            last_d   = gnt_id_s;
            mem_en_d = 1'b1;
            wren_d   = sel_we_s;
            addr_d   = sel_addr_s;
            to_mem_d = sel_wdata_s;
            if (sel_lock_s) begin
                lock_v_d     = 1'b1;
                lock_owner_d = gnt_id_s;
                // The count is the owner's run of grants taken while the other master waited.
                if (!lock_same_s) begin
                    lock_cnt_d = other_req_s ? 8'd1 : 8'd0;
                end else if (other_req_s && (lock_cnt_q < MAX_LOCK_C)) begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end else begin
                    lock_cnt_d = lock_cnt_q;
                end
            end else begin
                lock_v_d     = 1'b0;
                lock_owner_d = 1'b0;
                lock_cnt_d   = 8'd0;
            end
        end else begin
            last_d   = last_q;
            mem_en_d = 1'b0;
        end
    end

    // Read tag pipe and response steering back to the owning master.
    always_comb begin
        tag_v_d   = {tag_v_q[DEPTH-2:0], grant_s & ~sel_we_s};
        tag_id_d  = {tag_id_q[DEPTH-2:0], gnt_id_s};
        rvalid0_d = tag_v_q[DEPTH-1] & ~tag_id_q[DEPTH-1];
        rvalid1_d = tag_v_q[DEPTH-1] &  tag_id_q[DEPTH-1];
        if (rvalid0_d) begin
            rdata0_d = from_mem_i;
        end else begin
            rdata0_d = rdata0_q;
        end
        if (rvalid1_d) begin
            rdata1_d = from_mem_i;
        end else begin
            rdata1_d = rdata1_q;
        end
    end

    // State registers; M0 wins the first tie after reset.
    always_ff @(posedge tck_i) begin
        if (reset_i) begin
            last_q       <= 1'b1;
            lock_v_q     <= 1'b0;
            lock_owner_q <= 1'b0;
            lock_cnt_q   <= 8'd0;
            mem_en_q     <= 1'b0;
            wren_q       <= 1'b0;
            addr_q       <= 32'd0;
            to_mem_q     <= 64'd0;
            tag_v_q      <= {DEPTH{1'b0}};
            tag_id_q     <= {DEPTH{1'b0}};
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= 64'd0;
            rdata1_q     <= 64'd0;
        end else begin
            last_q       <= last_d;
            lock_v_q     <= lock_v_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            mem_en_q     <= mem_en_d;
            wren_q       <= wren_d;
            addr_q       <= addr_d;
            to_mem_q     <= to_mem_d;
            tag_v_q      <= tag_v_d;
            tag_id_q     <= tag_id_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign mem_en_o     = mem_en_q;
    assign wren_o       = wren_q;
    assign addr_o       = addr_q;
    assign to_mem_o     = to_mem_q;
    assign m0_if.rvalid = rvalid0_q;
    assign m1_if.rvalid = rvalid1_q;
    assign m0_if.rdata  = rdata0_q;
    assign m1_if.rdata  = rdata1_q;

endmodule

// File: tb/tb_jtag_mem_arbiter.sv
// Bench for jtag_mem_arbiter: two instances (memory latency 1 and 3) share one stimulus stream
// and are compared every cycle against a transaction-level model of the arbitration rules.
module tb_jtag_mem_arbiter;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int MAXL  = 16;

    logic        tck  = 1'b0;
    logic        rst  = 1'b1;
    logic        mclr = 1'b1;
    logic [1:0]  req  = 2'b00;
    logic [1:0]  we   = 2'b00;
    logic [1:0]  lk   = 2'b00;
    logic [31:0] ad [2];
    logic [63:0] wd [2];
    logic [1:0]  en, wr;
    logic [31:0] ma [2];
    logic [63:0] mt [2];
    logic [63:0] fm [2];
    logic [1:0]  g  [2];
    logic [1:0]  rv [2];
    logic [63:0] rd [2][2];

    always #5 tck = ~tck;

    jtag_mem_arbiter_if ia0(), ia1(), ib0(), ib1();
    assign ia0.req = req[0]; assign ia0.we = we[0]; assign ia0.lock = lk[0]; assign ia0.addr = ad[0]; assign ia0.wdata = wd[0];
    assign ia1.req = req[1]; assign ia1.we = we[1]; assign ia1.lock = lk[1]; assign ia1.addr = ad[1]; assign ia1.wdata = wd[1];
    assign ib0.req = req[0]; assign ib0.we = we[0]; assign ib0.lock = lk[0]; assign ib0.addr = ad[0]; assign ib0.wdata = wd[0];
    assign ib1.req = req[1]; assign ib1.we = we[1]; assign ib1.lock = lk[1]; assign ib1.addr = ad[1]; assign ib1.wdata = wd[1];
    assign g[0]  = {ia1.gnt, ia0.gnt};       assign g[1]  = {ib1.gnt, ib0.gnt};
    assign rv[0] = {ia1.rvalid, ia0.rvalid}; assign rv[1] = {ib1.rvalid, ib0.rvalid};
    assign rd[0][0] = ia0.rdata; assign rd[0][1] = ia1.rdata;
    assign rd[1][0] = ib0.rdata; assign rd[1][1] = ib1.rdata;

    jtag_mem_arbiter #(.MEM_LATENCY(LAT_A), .MAX_LOCK(MAXL)) dut_a (
        .tck_i(tck), .reset_i(rst), .m0_if(ia0), .m1_if(ia1),
        .mem_en_o(en[0]), .wren_o(wr[0]), .addr_o(ma[0]), .to_mem_o(mt[0]), .from_mem_i(fm[0]));
    jtag_mem_arbiter #(.MEM_LATENCY(LAT_B), .MAX_LOCK(MAXL)) dut_b (
        .tck_i(tck), .reset_i(rst), .m0_if(ib0), .m1_if(ib1),
        .mem_en_o(en[1]), .wren_o(wr[1]), .addr_o(ma[1]), .to_mem_o(mt[1]), .from_mem_i(fm[1]));

    // Memory stubs: one RAM per instance, read data presented LAT cycles after MEM_EN.
    logic [63:0] smem [2][256];
    logic [63:0] pipe [2][3];
    always @(posedge tck) begin
        for (int k = 0; k < 2; k++) begin
            if (mclr) begin
                for (int i = 0; i < 256; i++) smem[k][i] <= 64'h0;
            end else if (en[k] && wr[k]) begin
                smem[k][ma[k][7:0]] <= mt[k];
            end
            pipe[k][0] <= (en[k] && !wr[k]) ? smem[k][ma[k][7:0]] : 64'h0;
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end
    assign fm[0] = pipe[0][LAT_A-1];
    assign fm[1] = pipe[1][LAT_B-1];

    // Reference model state.
    typedef struct { int acc; int id; logic [63:0] d; } rd_t;
    rd_t         rq[$];
    logic [63:0] rmem [256];
    logic [63:0] e_rd [2][2];
    int          m_last, m_owner, m_cnt;
    bit          m_lv;
    logic        e_en, e_wr;
    logic [31:0] e_ad;
    logic [63:0] e_wd;
    int          cyc, last_p;
    logic [1:0]  g_seen [2];
    int          checks = 0;
    int          errors = 0;

    function automatic int lat(int k);
        return (k == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic chk(string tag, int k, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1; m_owner = 0; m_cnt = 0; m_lv = 1'b0;
        e_en = 1'b0; e_wr = 1'b0; e_ad = 32'h0; e_wd = 64'h0;
        rq.delete();
        for (int k = 0; k < 2; k++) for (int x = 0; x < 2; x++) e_rd[k][x] = 64'h0;
    endtask

    // Who gets the bus this cycle: -1 none, else master id.
    function automatic int predict();
        if (req == 2'b00) return -1;
        if (req == 2'b01) return 0;
        if (req == 2'b10) return 1;
        if (m_lv && (m_cnt < MAXL)) return m_owner;
        return 1 - m_last;
    endfunction

    task automatic apply_accept(int gi);
        bit other;
        other = req[1 - gi];
        e_en = 1'b1; e_wr = we[gi]; e_ad = ad[gi]; e_wd = wd[gi];
        if (we[gi]) rmem[ad[gi][7:0]] = wd[gi];
        else rq.push_back('{cyc, gi, rmem[ad[gi][7:0]]});
        if (lk[gi]) begin
            if (!(m_lv && (m_owner == gi))) m_cnt = other ? 1 : 0;
            else if (other && (m_cnt < MAXL)) m_cnt = m_cnt + 1;
            m_lv = 1'b1; m_owner = gi;
        end else begin
            m_lv = 1'b0; m_cnt = 0;
        end
        m_last = gi;
    endtask

    // One clock: check every output of both instances, then advance the model at the edge.
    task automatic cycle();
        int p;
        logic [1:0] eg;
        logic e_v;
        #1;
        while (rq.size() > 0 && (rq[0].acc + LAT_B + 2 < cyc)) void'(rq.pop_front());
        p = predict();
        eg = (p == 0) ? 2'b01 : ((p == 1) ? 2'b10 : 2'b00);
        for (int k = 0; k < 2; k++) begin
            g_seen[k] = g[k];
            chk("gnt", k, 64'(g[k]), 64'(eg));
            chk("mem_en", k, 64'(en[k]), 64'(e_en));
            chk("wren", k, 64'(wr[k]), 64'(e_wr));
            chk("addr", k, 64'(ma[k]), 64'(e_ad));
            chk("to_mem", k, mt[k], e_wd);
            for (int x = 0; x < 2; x++) begin
                e_v = 1'b0;
                foreach (rq[i]) begin
                    if ((rq[i].acc + lat(k) + 2 == cyc) && (rq[i].id == x)) begin
                        e_v = 1'b1;
                        e_rd[k][x] = rq[i].d;
                    end
                end
                chk(x == 0 ? "rvalid_m0" : "rvalid_m1", k, 64'(rv[k][x]), 64'(e_v));
                chk(x == 0 ? "rdata_m0" : "rdata_m1", k, rd[k][x], e_rd[k][x]);
            end
        end
        @(posedge tck);
        if (rst) model_reset();
        else if (p >= 0) apply_accept(p);
        else begin e_en = 1'b0; e_wr = 1'b0; end
        last_p = rst ? -1 : p;
        cyc++;
        @(negedge tck);
    endtask

    task automatic drive(int x, bit r, bit w, bit l, logic [31:0] a, logic [63:0] d);
        req[x] = r; we[x] = w; lk[x] = l; ad[x] = a; wd[x] = d;
    endtask

    task automatic reset_pulse();
        req = 2'b00; rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rmem[i] = 64'h0;
        ad[0] = 32'h0; ad[1] = 32'h0; wd[0] = 64'h0; wd[1] = 64'h0;
        cyc = 0; last_p = -1;
        repeat (3) @(posedge tck);
        @(negedge tck);
        model_reset();
        rst = 1'b0; mclr = 1'b0;

        // Write then read back on M0; read returns three cycles after acceptance.
        drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 64'hDEADBEEF_00000001);
        cycle();
        chk("t1_en", 0, 64'(en[0]), 64'h1);
        chk("t1_wren", 0, 64'(wr[0]), 64'h1);
        chk("t1_addr", 0, 64'(ma[0]), 64'h10);
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 64'h0);
        cycle();
        req[0] = 1'b0;
        cycle();
        chk("t1_rv_early", 0, 64'(rv[0][0]), 64'h0);
        cycle();
        chk("t1_rvalid", 0, 64'(rv[0][0]), 64'h1);
        chk("t1_rdata", 0, rd[0][0], 64'hDEADBEEF_00000001);
        cycle();
        cycle();
        chk("t1_rvalid_l3", 1, 64'(rv[1][0]), 64'h1);
        chk("t1_rdata_l3", 1, rd[1][0], 64'hDEADBEEF_00000001);
        repeat (2) cycle();

        // Continuous requests without lock alternate, starting with M0.
        reset_pulse();
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 64'h0);
        drive(1, 1'b1, 1'b1, 1'b0, 32'h20, 64'h1234_5678_9ABC_DEF0);
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("t2_alternate", 0, 64'(g_seen[0]), (i % 2 == 0) ? 64'h1 : 64'h2);
        end
        req = 2'b00;
        repeat (6) cycle();

        // M1 locks (with writes) while M0 waits: runs of 16 M1 grants, one M0 grant between.
        reset_pulse();
        drive(0, 1'b1, 1'b0, 1'b0, 32'h4, 64'h0);
        drive(1, 1'b1, 1'b1, 1'b1, 32'h5, 64'hCAFE_0000_0000_0005);
        for (int i = 0; i < 40; i++) begin
            cycle();
            chk("t3_lock_pattern", 0, 64'(g_seen[0]),
                ((i == 0) || ((i - 1) % 17 == 16)) ? 64'h1 : 64'h2);
        end
        req = 2'b00;
        repeat (6) cycle();

        // Interleaved reads from both masters return in order to the right owner.
        reset_pulse();
        drive(0, 1'b1, 1'b1, 1'b0, 32'h1, {$urandom, $urandom}); cycle(); req[0] = 1'b0;
        drive(1, 1'b1, 1'b1, 1'b0, 32'h2, {$urandom, $urandom}); cycle(); req[1] = 1'b0;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h3, {$urandom, $urandom}); cycle(); req[0] = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h1, 64'h0); cycle(); req[0] = 1'b0;
        drive(1, 1'b1, 1'b0, 1'b0, 32'h2, 64'h0); cycle(); req[1] = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h3, 64'h0); cycle(); req[0] = 1'b0;
        repeat (7) cycle();

        // Reset with two reads in flight drops their responses; first tie then goes to M0.
        reset_pulse();
        drive(0, 1'b1, 1'b0, 1'b0, 32'h1, 64'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h2, 64'h0);
        repeat (2) cycle();
        reset_pulse();
        for (int i = 0; i < 6; i++) begin
            chk("t5_no_rvalid", 0, 64'(rv[0]), 64'h0);
            chk("t5_no_rvalid", 1, 64'(rv[1]), 64'h0);
            chk("t5_mem_en", 0, 64'(en[0]), 64'h0);
            cycle();
        end
        drive(0, 1'b1, 1'b0, 1'b0, 32'h6, 64'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h7, 64'h0);
        cycle();
        chk("t5_first_tie", 0, 64'(g_seen[0]), 64'h1);
        req = 2'b00;
        repeat (4) cycle();

        // M0 request raised and withdrawn while M1 holds a lock: no M0 access.
        reset_pulse();
        drive(1, 1'b1, 1'b0, 1'b1, 32'h7, 64'h0);
        cycle();
        drive(0, 1'b1, 1'b1, 1'b0, 32'h9, 64'hBAD0_BAD0_BAD0_BAD0);
        cycle();
        chk("t6_m0_blocked", 0, 64'(g_seen[0]), 64'h2);
        chk("t6_m0_blocked", 1, 64'(g_seen[1]), 64'h2);
        req[0] = 1'b0;
        repeat (2) cycle();
        req = 2'b00;
        repeat (5) cycle();

        // Randomized traffic with legal hold/drop behaviour and a mid-run reset.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) reset_pulse();
            for (int x = 0; x < 2; x++) begin
                if (req[x] && (last_p != x)) begin
                    if ($urandom_range(0, 7) == 0) req[x] = 1'b0;
                end else begin
                    drive(x, ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
                          ($urandom_range(0, 3) == 0), 32'($urandom_range(0, 15)),
                          {$urandom, $urandom});
                end
            end
            cycle();
        end
        req = 2'b00;
        repeat (8) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
